mux_arb_n: RTL and testbench



---
 rtl/mux_arb_n_pkg.sv | 16 +
 rtl/mux_arb_n_rr_pick.sv | 41 ++++
 rtl/mux_arb_n.sv | 100 ++++++++++
 tb/tb_mux_arb_n.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mux_arb_n_pkg.sv
// ==== mux_arb_n_pkg : shared mode constants and select-width helper (rev 1.0) ====
`default_nettype none

package mux_arb_n_pkg;

  localparam int MODE_DIRETO      = 0;
  localparam int MODE_ROUND_ROBIN = 1;

  // Select width is clog2 of the channel count, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_arb_n_rr_pick.sv
// ==== rr_pick : combinational rotated-priority picker, search starts at 'start' (rev 1.0) ====
`default_nettype none

module rr_pick #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] start,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] idx,
  output logic            found
);

  logic [SELW:0]   w_sum;
  logic [SELW-1:0] w_pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    w_sum = '0;
    w_pos = '0;
    for (int k = 0; k < N; k++) begin
      // start is always < N, so one conditional subtract gives the wrap.
      w_sum = {1'b0, start} + (SELW+1)'(k);
      if (w_sum >= (SELW+1)'(N)) begin
        w_sum = w_sum - (SELW+1)'(N);
      end
      w_pos = w_sum[SELW-1:0];
      if (!found && req[w_pos]) begin
        found        = 1'b1;
        grant[w_pos] = 1'b1;
        idx          = w_pos;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_arb_n.sv
// ==== mux_arb_n : N-channel W-bit mux, direct or round-robin select, one-entry output buffer (rev 1.0) ====
`default_nettype none

module mux_arb_n
  import mux_arb_n_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = MODE_DIRETO
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [CHANNELS*WIDTH-1:0]    Entrada,
  input  logic [CHANNELS-1:0]          Valido,
  input  logic [sel_width(CHANNELS)-1:0] Controle,
  output logic [CHANNELS-1:0]          Aceito,
  output logic [WIDTH-1:0]             Resultado,
  output logic                         ResultadoValido,
  input  logic                         Pronto
);

  localparam int SELW = sel_width(CHANNELS);

  logic [CHANNELS-1:0] w_grant;
  logic [SELW-1:0]     w_idx;
  logic                w_found;
  logic                w_carga;
  logic                w_take;
  logic [WIDTH-1:0]    w_sel_data;

  assign w_carga = !ResultadoValido || Pronto;
  assign w_take  = w_carga && w_found && !Reset;
  assign Aceito  = w_take ? w_grant : '0;

  generate
    if (MODE == MODE_ROUND_ROBIN) begin : g_rr
      logic [SELW-1:0] r_ponteiro;
      logic            unused_controle;

      assign unused_controle = ^Controle;

      rr_pick #(
        .N    (CHANNELS),
        .SELW (SELW)
      ) u_pick (
        .req   (Valido),
        .start (r_ponteiro),
        .grant (w_grant),
        .idx   (w_idx),
        .found (w_found)
      );

      always_ff @(posedge Clock) begin
        if (Reset) begin
          r_ponteiro <= '0;
        end else if (w_take) begin
          r_ponteiro <= (w_idx == SELW'(CHANNELS-1)) ? '0 : w_idx + SELW'(1);
        end
      end
    end else begin : g_direct
      // Out-of-range selects (non-power-of-2 CHANNELS) simply match no channel.
      always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
          if (Controle == SELW'(i) && Valido[i]) begin
            w_grant[i] = 1'b1;
            w_idx      = SELW'(i);
            w_found    = 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant[i]) begin
        w_sel_data = Entrada[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Resultado       <= '0;
      ResultadoValido <= 1'b0;
    end else if (w_take) begin
      Resultado       <= w_sel_data;
      ResultadoValido <= 1'b1;
    end else if (Pronto && ResultadoValido) begin
      ResultadoValido <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_arb_n.sv
// ==== tb_mux_arb_n : directed self-checking bench for mux_arb_n, four configurations (rev 1.0) ====
`default_nettype none

module tb_mux_arb_n;

  logic clk = 1'b0;
  logic rst;

  // A: 8b x4 direct, B: 8b x4 round-robin, C: 16b x3 round-robin, D: 16b x3 direct
  logic [31:0] a_ent, b_ent;
  logic [3:0]  a_val, b_val, a_acc, b_acc;
  logic [1:0]  a_ctl, b_ctl;
  logic [7:0]  a_res, b_res;
  logic        a_rv, b_rv, a_pr, b_pr;

  logic [47:0] c_ent, d_ent;
  logic [2:0]  c_val, d_val, c_acc, d_acc;
  logic [1:0]  c_ctl, d_ctl;
  logic [15:0] c_res, d_res;
  logic        c_rv, d_rv, c_pr, d_pr;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp8 [4];

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_a (
    .Clock(clk), .Reset(rst), .Entrada(a_ent), .Valido(a_val), .Controle(a_ctl),
    .Aceito(a_acc), .Resultado(a_res), .ResultadoValido(a_rv), .Pronto(a_pr));

  mux_arb_n #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_b (
    .Clock(clk), .Reset(rst), .Entrada(b_ent), .Valido(b_val), .Controle(b_ctl),
    .Aceito(b_acc), .Resultado(b_res), .ResultadoValido(b_rv), .Pronto(b_pr));

  mux_arb_n #(.WIDTH(16), .CHANNELS(3), .MODE(1)) u_c (
    .Clock(clk), .Reset(rst), .Entrada(c_ent), .Valido(c_val), .Controle(c_ctl),
    .Aceito(c_acc), .Resultado(c_res), .ResultadoValido(c_rv), .Pronto(c_pr));

  mux_arb_n #(.WIDTH(16), .CHANNELS(3), .MODE(0)) u_d (
    .Clock(clk), .Reset(rst), .Entrada(d_ent), .Valido(d_val), .Controle(d_ctl),
    .Aceito(d_acc), .Resultado(d_res), .ResultadoValido(d_rv), .Pronto(d_pr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; registered outputs are settled then.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp8[0] = 8'hAA; exp8[1] = 8'hBB; exp8[2] = 8'hCC; exp8[3] = 8'hDD;
    rst = 1'b1;
    a_ent = 32'hDDCCBBAA; a_val = 4'b1111; a_ctl = 2'd0; a_pr = 1'b1;
    b_ent = 32'hDDCCBBAA; b_val = 4'b1111; b_ctl = 2'd0; b_pr = 1'b1;
    c_ent = {16'h3333, 16'h2222, 16'h1111}; c_val = 3'b111; c_ctl = 2'd0; c_pr = 1'b1;
    d_ent = {16'h3333, 16'h2222, 16'h1111}; d_val = 3'b111; d_ctl = 2'd0; d_pr = 1'b1;

    tick; tick;
    chk("rst_acc_a", 32'(a_acc), 32'h0);
    chk("rst_acc_b", 32'(b_acc), 32'h0);
    chk("rst_res_a", 32'(a_res), 32'h00);
    chk("rst_rv_a",  32'(a_rv),  32'h0);
    chk("rst_rv_b",  32'(b_rv),  32'h0);
    b_val = 4'b0000; c_val = 3'b000; d_val = 3'b000;
    rst = 1'b0;

    // Direct select stepping over every channel
    for (int c = 0; c < 4; c++) begin
      a_ctl = 2'(c);
      #1 chk("dir_acc", 32'(a_acc), 32'(1) << c);
      tick;
      chk("dir_res", 32'(a_res), 32'(exp8[c]));
      chk("dir_rv",  32'(a_rv),  32'h1);
    end

    // Selected channel not requesting: buffered DD drains, no reload
    a_ctl = 2'd2; a_val = 4'b1011;
    #1 chk("dir_nogrant_acc", 32'(a_acc), 32'h0);
    tick;
    chk("dir_drain_rv",  32'(a_rv),  32'h0);
    chk("dir_drain_res", 32'(a_res), 32'hDD);

    // Backpressure
    a_ctl = 2'd0; a_val = 4'b0001;
    #1 chk("bp_load_acc", 32'(a_acc), 32'h1);
    tick;
    chk("bp_load_res", 32'(a_res), 32'hAA);
    a_pr = 1'b0; a_val = 4'b0010; a_ctl = 2'd1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_hold_acc", 32'(a_acc), 32'h0);
      tick;
      chk("bp_hold_res", 32'(a_res), 32'hAA);
      chk("bp_hold_rv",  32'(a_rv),  32'h1);
    end
    a_pr = 1'b1;
    #1 chk("bp_release_acc", 32'(a_acc), 32'h2);
    tick;
    chk("bp_release_res", 32'(a_res), 32'hBB);
    chk("bp_release_rv",  32'(a_rv),  32'h1);
    a_val = 4'b0000;
    tick;
    chk("bp_empty_rv", 32'(a_rv), 32'h0);

    // Reset while a word is held drops it
    a_val = 4'b0100; a_ctl = 2'd2; a_pr = 1'b0;
    tick;
    chk("midrst_load_res", 32'(a_res), 32'hCC);
    a_val = 4'b0000; rst = 1'b1;
    tick;
    chk("midrst_rv",  32'(a_rv),  32'h0);
    chk("midrst_res", 32'(a_res), 32'h00);
    rst = 1'b0; a_pr = 1'b1;

    // Round-robin, all requesting: 0,1,2,3,0,1,2,3 at full rate
    b_val = 4'b1111; b_pr = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_acc", 32'(b_acc), 32'(1) << (k % 4));
      tick;
      chk("rr_res", 32'(b_res), 32'(exp8[k % 4]));
      chk("rr_rv",  32'(b_rv),  32'h1);
    end
    // Pointer and buffer freeze under backpressure
    b_pr = 1'b0;
    #1 chk("rr_bp_acc", 32'(b_acc), 32'h0);
    tick;
    chk("rr_bp_res", 32'(b_res), 32'hDD);
    b_pr = 1'b1;
    #1 chk("rr_bp_release_acc", 32'(b_acc), 32'h1);
    tick;
    chk("rr_bp_release_res", 32'(b_res), 32'hAA);
    b_val = 4'b0000;

    // 16-bit, 3 channels, round-robin with a hole at channel 1
    c_val = 3'b101; c_pr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr3_acc", 32'(c_acc), (k % 2 == 0) ? 32'h1 : 32'h4);
      tick;
      chk("rr3_res", 32'(c_res), (k % 2 == 0) ? 32'h1111 : 32'h3333);
    end
    c_val = 3'b000;

    // 16-bit, 3 channels, direct select past the last channel
    d_ctl = 2'd3; d_val = 3'b111; d_pr = 1'b1;
    #1 chk("dir3_oob_acc", 32'(d_acc), 32'h0);
    tick;
    chk("dir3_oob_rv", 32'(d_rv), 32'h0);
    d_ctl = 2'd2;
    #1 chk("dir3_acc", 32'(d_acc), 32'h4);
    tick;
    chk("dir3_res", 32'(d_res), 32'h3333);
    chk("dir3_rv",  32'(d_rv),  32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
